icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache. One instance per core.
- Sits between the datapath fetch stage and the coherence/arbitration memory controller.
- Serves instruction fetches from local frames. On a miss, issues a single-word iREN request to the controller and holds it until the controller drops iwait.
- Exposes saturating hit and miss counters for performance checks.

---
 rtl/icache_direct.sv | 160 ++++++++++++++++
 tb/tb_icache_direct.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with a single-word miss FSM.
// Define ICACHE_PREFETCH_EN to add a next-line prefetch after each demand fill.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             flush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - IDX;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
`ifdef ICACHE_PREFETCH_EN
  localparam logic [1:0] S_PREF = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [29:0]      maddr_q, maddr_d;
  logic             drop_q, drop_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [IDX-1:0]   req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX-1:0]   m_idx;
  logic [TAG_W-1:0] m_tag;
  logic             lookup;
  logic             busy;
  logic             done;
  logic             miss_ev;
  logic             unused_lsb;

  assign req_idx    = imemaddr[IDX+1:2];
  assign req_tag    = imemaddr[31:IDX+2];
  assign m_idx      = maddr_q[IDX-1:0];
  assign m_tag      = maddr_q[29:IDX];
  assign unused_lsb = ^imemaddr[1:0];

  assign lookup = imemREN && valid_q[req_idx]
               && (tag_q[req_idx] == req_tag);
  assign busy   = (state_q != S_IDLE);
  assign done   = busy && !iwait;

`ifdef ICACHE_PREFETCH_EN
  logic [29:0]      nxt_addr;
  logic [IDX-1:0]   n_idx;
  logic [TAG_W-1:0] n_tag;
  logic             nxt_present;

  assign nxt_addr    = maddr_q + 30'd1;
  assign n_idx       = nxt_addr[IDX-1:0];
  assign n_tag       = nxt_addr[29:IDX];
  // A flush in this cycle invalidates the next line too
  assign nxt_present = valid_q[n_idx] && !flush
                    && (tag_q[n_idx] == n_tag);
`endif

  always_comb begin
    ihit = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): ihit = lookup;
`ifdef ICACHE_PREFETCH_EN
      (state_q == S_PREF): ihit = lookup && (req_idx != m_idx);
`endif
      default: ihit = 1'b0;
    endcase
  end

  assign imemload   = ihit ? data_q[req_idx] : 32'd0;
  assign iREN       = busy;
  assign iaddr      = busy ? {maddr_q, 2'b00} : 32'd0;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign miss_ev    = (state_q == S_IDLE) && imemREN && !lookup;

  always_comb begin
    state_d = state_q;
    maddr_d = maddr_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    if (flush)
      valid_d = '0;
    if (busy && flush)
      drop_d = 1'b1;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (miss_ev) begin
          state_d = S_FILL;
          maddr_d = imemaddr[31:2];
        end
      end
      done: begin
        valid_d[m_idx] = !(drop_q || flush);
        drop_d         = 1'b0;
        state_d        = S_IDLE;
`ifdef ICACHE_PREFETCH_EN
        if ((state_q == S_FILL) && !nxt_present) begin
          state_d = S_PREF;
          maddr_d = nxt_addr;
        end
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (ihit && (hit_q != '1))
      hit_d = hit_q + CNT_W'(1);
    if (miss_ev && (miss_q != '1))
      miss_d = miss_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      maddr_q <= '0;
      drop_q  <= 1'b0;
      valid_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      maddr_q <= maddr_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Frame payload needs no reset; the valid bits gate it
  always_ff @(posedge CLK) begin
    if (nRST && done) begin
      tag_q[m_idx]  <= m_tag;
      data_q[m_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: random and directed fetch traffic against a
// transaction-level cache model keyed by full word addresses.
module tb_icache_direct;

  localparam int SETS  = 16;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef ICACHE_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             nRST;
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             ihit;
  logic [31:0]      imemload;
  logic             flush;
  logic             iREN;
  logic [31:0]      iaddr;
  logic             iwait;
  logic [31:0]      iload;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  always #5 CLK = ~CLK;

  icache_direct #(.SETS(SETS), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .flush      (flush),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: lines hold whole word addresses; one outstanding request
  bit          mv [SETS];
  logic [29:0] mw [SETS];
  logic [31:0] md [SETS];
  bit          r_on;
  bit          r_pf;
  bit          r_drop;
  logic [29:0] r_addr;
  int          m_hits;
  int          m_miss;

  task automatic model_reset();
    foreach (mv[i]) mv[i] = 1'b0;
    r_on   = 1'b0;
    r_pf   = 1'b0;
    r_drop = 1'b0;
    r_addr = '0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic cycle(input bit ren, input logic [31:0] a, input bit fl,
                       input bit iw, input logic [31:0] ld, input bit rst);
    logic [29:0] w;
    logic [29:0] nxt;
    int unsigned s;
    int unsigned rs;
    bit look;
    bit e_hit;
    imemREN  = ren;
    imemaddr = a;
    flush    = fl;
    iwait    = iw;
    iload    = ld;
    nRST     = !rst;
    @(negedge CLK);
    w     = a[31:2];
    s     = w % SETS;
    rs    = r_addr % SETS;
    look  = ren && mv[s] && (mw[s] == w);
    e_hit = r_on ? (r_pf && look && (s != rs)) : look;
    chk("ihit", {31'd0, ihit}, {31'd0, e_hit});
    chk("imemload", imemload, e_hit ? md[s] : 32'd0);
    chk("iREN", {31'd0, iREN}, {31'd0, r_on});
    chk("iaddr", iaddr, r_on ? {r_addr, 2'b00} : 32'd0);
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_miss));
    if (rst) begin
      model_reset();
    end else begin
      if (e_hit && m_hits < SAT) m_hits++;
      if (fl) foreach (mv[i]) mv[i] = 1'b0;
      if (r_on && !iw) begin
        mv[rs] = !(r_drop || fl);
        mw[rs] = r_addr;
        md[rs] = ld;
        r_drop = 1'b0;
        nxt    = r_addr + 30'd1;
        if (PF && !r_pf && !(mv[nxt % SETS] && mw[nxt % SETS] == nxt)) begin
          r_pf   = 1'b1;
          r_addr = nxt;
        end else begin
          r_on = 1'b0;
        end
      end else if (r_on) begin
        if (fl) r_drop = 1'b1;
      end else if (ren && !look) begin
        if (m_miss < SAT) m_miss++;
        r_on   = 1'b1;
        r_pf   = 1'b0;
        r_drop = 1'b0;
        r_addr = w;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1);
  endtask

  // miss, one-cycle fill, then a cycle that drains any prefetch
  task automatic fetch_fill(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, a, 1'b0, 1'b1, 32'd0, 1'b0);
    cycle(1'b0, a, 1'b0, 1'b0, d, 1'b0);
    cycle(1'b0, a, 1'b0, 1'b0, ~d, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] tags [4];
    tags[0] = 32'h0;
    tags[1] = 32'h1;
    tags[2] = 32'h2;
    tags[3] = 32'h3FFFFFF;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0;
    flush = 1'b0; iwait = 1'b1; iload = '0;
    @(posedge CLK);
    #1;
    model_reset();

    // cold miss then hit
    cycle(1'b1, 32'h40, 1'b0, 1'b1, 32'd0, 1'b0);
    repeat (3) cycle(1'b1, 32'h40, 1'b0, 1'b1, 32'd0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 1'b0, 32'h2001000A, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t1_miss", 32'(miss_count), 32'd1);
    chk("t1_hit", 32'(hit_count), 32'd1);

    // conflict eviction on index 0
    do_reset();
    fetch_fill(32'h40, 32'h11111111);
    fetch_fill(32'h80, 32'h22222222);
    cycle(1'b1, 32'h40, 1'b0, 1'b1, 32'd0, 1'b0);
    chk("t2_miss", 32'(miss_count), 32'd3);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h33333333, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // flush during fill drops the frame
    do_reset();
    cycle(1'b1, 32'h100, 1'b0, 1'b1, 32'd0, 1'b0);
    cycle(1'b0, 32'h100, 1'b1, 1'b1, 32'd0, 1'b0);
    cycle(1'b0, 32'h100, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h100, 1'b0, 1'b1, 32'd0, 1'b0);
    chk("t3_miss", 32'(miss_count), 32'd2);
    chk("t3_iREN", {31'd0, iREN}, 32'd1);
    chk("t3_iaddr", iaddr, 32'h100);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h5, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h6, 1'b0);

    // reset mid-fill
    do_reset();
    cycle(1'b1, 32'h200, 1'b0, 1'b1, 32'd0, 1'b0);
    cycle(1'b0, 32'h200, 1'b0, 1'b1, 32'd0, 1'b1);
    chk("t4_iREN", {31'd0, iREN}, 32'd0);
    chk("t4_hits", 32'(hit_count), 32'd0);
    chk("t4_miss", 32'(miss_count), 32'd0);
    cycle(1'b1, 32'h200, 1'b0, 1'b1, 32'd0, 1'b0);
    chk("t4_remiss", 32'(miss_count), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h7, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h8, 1'b0);

    // hit counter saturation
    do_reset();
    fetch_fill(32'h300, 32'h12345678);
    repeat (20) cycle(1'b1, 32'h300, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t5_sat", 32'(hit_count), 32'hF);

`ifdef ICACHE_PREFETCH_EN
    // next-line prefetch wraps to address 0
    do_reset();
    cycle(1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 32'd0, 1'b0);
    cycle(1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0);
    chk("t6_iREN", {31'd0, iREN}, 32'd1);
    chk("t6_iaddr", iaddr, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0BADF00D, 1'b0);
    cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 1'b0);
    chk("t6_miss", 32'(miss_count), 32'd1);
    chk("t6_hit", 32'(hit_count), 32'd1);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      a = (tags[$urandom_range(0, 3)] << 6)
        | (32'($urandom_range(0, SETS - 1)) << 2)
        | 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 9) < 8, a,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) < 6,
            $urandom,
            $urandom_range(0, 59) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
